lcd_hd44780_ctrl: RTL and testbench
===================================

# lcd_hd44780_ctrl

Parametrised HD44780 character-LCD controller that replaces the fixed-function initialiser in `LCD_Controller_TOP`. After reset it runs the complete power-up and initialisation sequence, then accepts command and data bytes from upstream logic over a valid/ready handshake. It supports an 8-bit or 4-bit bus, derives every delay from the clock frequency, and drives the panel pins (Enable, RS, RW, Dados) directly.

## Interface
- CLK_FREQ_MHZ, 50: clock frequency in MHz; 1 µs = CLK_FREQ_MHZ cycles (US).
- BUS_WIDTH, 8: 8 or 4; in 4-bit mode only Dados[7:4] carries data.
- TWO_LINES, 1: 1 → N=1 (two lines) in Function Set; 0 → N=0.
- POWERUP_US, 20000: power-up wait in µs; reduced in simulation.

- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high.
- In_Valid  in  1  upstream byte available.
- In_RS  in  1  0 = command, 1 = character data.
- In_Data  in  8  byte to write.
- In_Ready  out  1  high only in IDLE.
- Init_Done  out  1  sticky; set on first entry to IDLE.
- Estado  out  3  current FSM state code.
- Enable  out  1  LCD E pin.
- RS  out  1  LCD RS pin.
- RW  out  1  LCD RW pin; constant 0 (write only).
- Dados  out  8  LCD DB7..DB0.

## Operation
- Reset values: Estado=0, Enable=0, RS=0, RW=0, Dados=8'h00, In_Ready=0, Init_Done=0. All internal counters are cleared.
- FSM states and Estado codes:
  - 0 PWRUP: wait POWERUP_US·US cycles.
  - 1 INIT: load the next init step and go to SETUP.
  - 2 IDLE: wait for a handshake.
  - 3 SETUP: drive RS/Dados for US cycles.
  - 4 PULSE: Enable=1 for US cycles.
  - 5 HOLD: Enable=0, hold RS/Dados for US cycles.
  - 6 EXEC: wait the execution delay, then return to INIT (during init) or IDLE.
- Init sequence, as (value, post-delay):
  - 8-bit mode: 0x30 (4100 µs), 0x30 (100 µs), 0x30 (40 µs).
  - 4-bit mode: the same three steps as single nibbles 0x3, followed by nibble 0x2 (40 µs).
  - Both modes then send full commands with RS=0: Function Set {0,0,1,DL,N,0,0,0} (40 µs), 0x08 (40 µs), 0x01 (1640 µs, regardless of macro), 0x06 (40 µs), 0x0C (40 µs). DL=1 for 8-bit, DL=0 for 4-bit.
- Handshake: a transfer occurs on the cycle with In_Valid && In_Ready. In_RS and In_Data are captured that cycle. In_Ready is 0 from the next cycle until the return to IDLE. In_Valid outside IDLE is ignored; no byte is queued.
- 4-bit transfers: a full byte goes out as two SETUP/PULSE/HOLD sequences on Dados[7:4], high nibble first, then low nibble. Dados[3:0]=0. EXEC follows the second nibble only.
- User byte EXEC delay: 40 µs, except as set by the macro under Configuration.
- Dados and RS change only on entry to SETUP and stay stable through HOLD.
- Delay counter width is $clog2(max(POWERUP_US,4100)·CLK_FREQ_MHZ + 1).
- Reset asserted in any state returns the FSM to PWRUP with the reset values above. Init_Done clears.

## Timing
- Latency from handshake to Enable rising: 1 + US cycles. Enable high time is exactly US cycles.
- Byte cycle, IDLE to IDLE, 8-bit: 3·US + 40·US + 1 cycles (±1 for the state-entry cycle). 4-bit adds 3·US.
- In_Ready rises the cycle the FSM enters IDLE. Init_Done rises in the same cycle on the first entry.
- Init completes no earlier than POWERUP_US + 4100 + 100 + 1640 + 4·40 µs.

## Configuration
- `LCD_CTRL_LONG_EXEC_EN` defined: a user command with RS=0 and In_Data[7:2]==0, In_Data≠0 (Clear 0x01, Home 0x02/0x03) gets a 1640 µs EXEC delay.
- Not defined: all user bytes get 40 µs. Upstream must delay after Clear/Home itself.
- Init-sequence delays are unaffected either way.

## Test plan
- Reset, then CLK_FREQ_MHZ=1, POWERUP_US=100, BUS_WIDTH=8 → Dados 0x30,0x30,0x30,0x38,0x08,0x01,0x06,0x0C, each sampled on Enable fall. RS=0 and RW=0 throughout. Init_Done=1 and Estado=2 afterwards.
- After init, send In_RS=1, In_Data=0x41 → RS=1, Dados=0x41. Enable high exactly 1 cycle. In_Ready low for ≈44 cycles.
- BUS_WIDTH=4, send 0xA5 with RS=1 → two Enable pulses with Dados[7:4]=0xA then 0x5, Dados[3:0]=0. Init shows nibbles 3,3,3,2, then Function Set 0x28 as nibbles 2,8.
- With `LCD_CTRL_LONG_EXEC_EN`, send 0x01 with RS=0 → In_Ready low ≥1640 cycles. Without the macro → ≈44 cycles.
- In_Valid held high during init and EXEC → no extra Enable pulses. Exactly one transfer per IDLE handshake.
- Reset pulsed during PULSE → next cycle Enable=0, Estado=0, Init_Done=0, and the init sequence restarts from the beginning.

Source files
------------

// File: rtl/lcd_hd44780_ctrl_if.sv
// Upstream byte handshake for lcd_hd44780_ctrl: the producer is the master,
// the LCD controller is the slave.
interface lcd_hd44780_ctrl_if;
    logic       In_Valid;
    logic       In_RS;
    logic [7:0] In_Data;
    logic       In_Ready;

    modport master (output In_Valid, output In_RS, output In_Data, input In_Ready);
    modport slave  (input In_Valid, input In_RS, input In_Data, output In_Ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD controller: power-up wait, init sequence, then byte writes over valid/ready.
// Optional macro LCD_CTRL_LONG_EXEC_EN: user Clear/Home commands get the long 1640 us execution delay.
module lcd_hd44780_ctrl #(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int BUS_WIDTH    = 8,
    parameter int TWO_LINES    = 1,
    parameter int POWERUP_US   = 20000
) (
    input  logic                     Clock,
    input  logic                     Reset,
    lcd_hd44780_ctrl_if.slave        up,
    output logic                     Init_Done,
    output logic [2:0]               Estado,
    output logic                     Enable,
    output logic                     RS,
    output logic                     RW,
    output logic [7:0]               Dados
);
    localparam int MAX_US = (POWERUP_US > 4100) ? POWERUP_US : 4100;
    localparam int CW     = $clog2(MAX_US * CLK_FREQ_MHZ + 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] US_C     = CW'(CLK_FREQ_MHZ);
    localparam logic [CW-1:0] US_LAST  = CW'(CLK_FREQ_MHZ - 1);
    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_US * CLK_FREQ_MHZ - 1);
    localparam bit            NIBBLE   = (BUS_WIDTH == 4);
    localparam int            N_BOOT   = NIBBLE ? 4 : 3;
    localparam logic [3:0]    N_STEPS  = 4'(N_BOOT + 5);
    localparam logic [7:0]    FUNC_SET = {2'b00, 1'b1, (NIBBLE ? 1'b0 : 1'b1),
                                          ((TWO_LINES != 0) ? 1'b1 : 1'b0), 3'b000};

    typedef enum logic [2:0] {
        PWRUP = 3'd0, INIT = 3'd1, IDLE = 3'd2, SETUP = 3'd3,
        PULSE = 3'd4, HOLD = 3'd5, EXEC = 3'd6
    } state_t;

    typedef struct packed {
        logic        single;
        logic [7:0]  value;
        logic [12:0] delay_us;
    } step_t;

    // Boot steps are 0x30 wake-ups (single nibbles in 4-bit mode, plus the 0x2 switch), then full commands.
    function automatic step_t init_step(input logic [3:0] idx);
        step_t s;
        s = '{single: 1'b0, value: 8'h00, delay_us: 13'd40};
        if (idx < 4'(N_BOOT)) begin
            s.single = NIBBLE;
            s.value  = NIBBLE ? 8'h03 : 8'h30;
            case (idx)
                4'd0:    s.delay_us = 13'd4100;
                4'd1:    s.delay_us = 13'd100;
                4'd3:    s.value    = 8'h02;
                default: s.delay_us = 13'd40;
            endcase
        end else begin
            case (idx - 4'(N_BOOT))
                4'd0:    s.value = FUNC_SET;
                4'd1:    s.value = 8'h08;
                4'd2:    begin s.value = 8'h01; s.delay_us = 13'd1640; end
                4'd3:    s.value = 8'h06;
                4'd4:    s.value = 8'h0C;
                default: s.value = 8'h00;
            endcase
        end
        return s;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, exec_last_q, exec_last_d;
    logic [3:0]      step_q, step_d;
    logic [7:0]      byte_q, byte_d, dados_q, dados_d;
    logic            cmd_rs_q, cmd_rs_d, single_q, single_d, phase_q, phase_d;
    logic            rs_pin_q, rs_pin_d, enable_q, ready_q, done_q;
    logic [12:0]     usr_us_s;
    step_t           boot_s;

    assign boot_s = init_step(step_q);

    // Execution delay for a user byte.
    always_comb begin
`ifdef LCD_CTRL_LONG_EXEC_EN
        if (!up.In_RS && (up.In_Data[7:2] == 6'd0) && (up.In_Data != 8'd0)) begin
            usr_us_s = 13'd1640;
        end else begin
            usr_us_s = 13'd40;
        end
`else
        usr_us_s = 13'd40;
`endif
    end

    // Next-state logic; every timed state runs its counter from 0 up to its last cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + ONE;
        step_d      = step_q;
        byte_d      = byte_q;
        cmd_rs_d    = cmd_rs_q;
        single_d    = single_q;
        phase_d     = phase_q;
        exec_last_d = exec_last_q;
        case (state_q)
            PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    state_d = PWRUP;
                end
            end
            INIT: begin
                state_d     = SETUP;
                cnt_d       = '0;
                byte_d      = boot_s.value;
                cmd_rs_d    = 1'b0;
                single_d    = boot_s.single;
                phase_d     = 1'b0;
                exec_last_d = CW'(boot_s.delay_us) * US_C - ONE;
                step_d      = step_q + 4'd1;
            end
            IDLE: begin
                cnt_d = '0;
                if (up.In_Valid && ready_q) begin
                    state_d     = SETUP;
                    byte_d      = up.In_Data;
                    cmd_rs_d    = up.In_RS;
                    single_d    = 1'b0;
                    phase_d     = 1'b0;
                    exec_last_d = CW'(usr_us_s) * US_C - ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP, PULSE: begin
                if (cnt_q == US_LAST) begin
                    state_d = (state_q == SETUP) ? PULSE : HOLD;
                    cnt_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (cnt_q == US_LAST) begin
                    cnt_d = '0;
                    if (NIBBLE && !single_q && !phase_q) begin
                        phase_d = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = EXEC;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            EXEC: begin
                if (cnt_q == exec_last_q) begin
                    cnt_d   = '0;
                    state_d = (step_q == N_STEPS) ? IDLE : INIT;
                end else begin
                    state_d = EXEC;
                end
            end
            default: begin
                state_d = PWRUP;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values are loaded only when SETUP is entered and then held through HOLD.
    always_comb begin
        dados_d  = dados_q;
        rs_pin_d = rs_pin_q;
        if ((state_d == SETUP) && (state_q != SETUP)) begin
            rs_pin_d = cmd_rs_d;
            if (!NIBBLE) begin
                dados_d = byte_d;
            end else if (single_d || phase_d) begin
                dados_d = {byte_d[3:0], 4'h0};
            end else begin
                dados_d = {byte_d[7:4], 4'h0};
            end
        end else begin
            rs_pin_d = rs_pin_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= PWRUP;
            cnt_q       <= '0;
            step_q      <= 4'd0;
            byte_q      <= 8'h00;
            cmd_rs_q    <= 1'b0;
            single_q    <= 1'b0;
            phase_q     <= 1'b0;
            exec_last_q <= '0;
            dados_q     <= 8'h00;
            rs_pin_q    <= 1'b0;
            enable_q    <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            byte_q      <= byte_d;
            cmd_rs_q    <= cmd_rs_d;
            single_q    <= single_d;
            phase_q     <= phase_d;
            exec_last_q <= exec_last_d;
            dados_q     <= dados_d;
            rs_pin_q    <= rs_pin_d;
            enable_q    <= (state_d == PULSE);
            ready_q     <= (state_d == IDLE);
            done_q      <= done_q | (state_d == IDLE);
        end
    end

    assign up.In_Ready = ready_q;
    assign Init_Done   = done_q;
    assign Estado      = state_q;
    assign Enable      = enable_q;
    assign RS          = rs_pin_q;
    assign RW          = 1'b0;
    assign Dados       = dados_q;
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: an 8-bit and a 4-bit instance at 1 MHz, checked against a
// pulse-level model of what each Enable fall must present on RS/Dados.
module tb_lcd_hd44780_ctrl;
    logic clk = 1'b0;
    logic rst8 = 1'b1, rst4 = 1'b1;
    int   checks = 0, errors = 0, cyc = 0;

    lcd_hd44780_ctrl_if if8();
    lcd_hd44780_ctrl_if if4();

    logic       done8, done4, en8, en4, rs8, rs4, rw8, rw4;
    logic [2:0] est8, est4;
    logic [7:0] dq8, dq4;

    lcd_hd44780_ctrl #(.CLK_FREQ_MHZ(1), .BUS_WIDTH(8), .TWO_LINES(1), .POWERUP_US(100)) dut8 (
        .Clock(clk), .Reset(rst8), .up(if8), .Init_Done(done8), .Estado(est8),
        .Enable(en8), .RS(rs8), .RW(rw8), .Dados(dq8));

    lcd_hd44780_ctrl #(.CLK_FREQ_MHZ(1), .BUS_WIDTH(4), .TWO_LINES(1), .POWERUP_US(100)) dut4 (
        .Clock(clk), .Reset(rst4), .up(if4), .Init_Done(done4), .Estado(est4),
        .Enable(en4), .RS(rs4), .RW(rw4), .Dados(dq4));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

`ifdef LCD_CTRL_LONG_EXEC_EN
    localparam int CLEAR_LOW = 3 + 1640;
`else
    localparam int CLEAR_LOW = 3 + 40;
`endif

    // Model state: expected {RS, Dados} per Enable fall, per instance.
    logic [8:0] exp0[$];
    logic [8:0] exp1[$];
    int         pulses[2], hi_cnt[2], rel_cyc[2], init_cyc[2];
    logic       prev_en[2], prev_done[2];
    logic [7:0] last_dq[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_raw(input int d, input logic [8:0] v);
        if (d == 0) exp0.push_back(v);
        else exp1.push_back(v);
    endtask

    // A byte is one pulse on an 8-bit bus, two nibble pulses (high first) on a 4-bit bus.
    task automatic push_byte(input int d, input logic rs, input logic [7:0] b);
        if (d == 0) begin
            push_raw(d, {rs, b});
        end else begin
            push_raw(d, {rs, b[7:4], 4'h0});
            push_raw(d, {rs, b[3:0], 4'h0});
        end
    endtask

    task automatic push_init(input int d);
        logic [7:0] fs;
        fs = {2'b00, 1'b1, (d == 0) ? 1'b1 : 1'b0, 1'b1, 3'b000};
        for (int i = 0; i < 3; i++) push_raw(d, 9'h030);
        if (d == 1) push_raw(d, 9'h020);
        push_byte(d, 1'b0, fs);
        push_byte(d, 1'b0, 8'h08);
        push_byte(d, 1'b0, 8'h01);
        push_byte(d, 1'b0, 8'h06);
        push_byte(d, 1'b0, 8'h0C);
    endtask

    task automatic pop(input int d, output logic [8:0] v, output logic ok);
        ok = 1'b0;
        v  = 9'h000;
        if (d == 0 && exp0.size() > 0) begin v = exp0.pop_front(); ok = 1'b1; end
        else if (d == 1 && exp1.size() > 0) begin v = exp1.pop_front(); ok = 1'b1; end
        else ok = 1'b0;
    endtask

    function automatic logic rdy_of(input int d);
        return (d == 0) ? if8.In_Ready : if4.In_Ready;
    endfunction

    function automatic logic en_of(input int d);
        return (d == 0) ? en8 : en4;
    endfunction

    task automatic drive(input int d, input logic v, input logic rs, input logic [7:0] data);
        if (d == 0) begin if8.In_Valid = v; if8.In_RS = rs; if8.In_Data = data; end
        else begin if4.In_Valid = v; if4.In_RS = rs; if4.In_Data = data; end
    endtask

    // Per-cycle compare process.
    initial forever begin
        logic       en, rs, rdy, done, rst, vld, irs, ok;
        logic [7:0] dq, idat;
        logic [2:0] es;
        logic [8:0] v;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            en   = (d == 0) ? en8 : en4;
            rs   = (d == 0) ? rs8 : rs4;
            dq   = (d == 0) ? dq8 : dq4;
            es   = (d == 0) ? est8 : est4;
            done = (d == 0) ? done8 : done4;
            rst  = (d == 0) ? rst8 : rst4;
            rdy  = rdy_of(d);
            vld  = (d == 0) ? if8.In_Valid : if4.In_Valid;
            irs  = (d == 0) ? if8.In_RS : if4.In_RS;
            idat = (d == 0) ? if8.In_Data : if4.In_Data;
            check("rw_low", (d == 0) ? rw8 : rw4, 1'b0);
            if (rst) begin
                if (d == 0) exp0.delete();
                else exp1.delete();
                push_init(d);
                prev_en[d] = 1'b0; prev_done[d] = 1'b0;
                hi_cnt[d] = 0; pulses[d] = 0; rel_cyc[d] = cyc;
            end else begin
                check("ready_only_idle", rdy, (es == 3'd2));
                if (d == 1) check("low_nibble_zero", dq[3:0], 4'h0);
                if (en) hi_cnt[d]++;
                if (!en && prev_en[d]) begin
                    check("enable_width", hi_cnt[d], 1);
                    pop(d, v, ok);
                    check("pulse_expected", ok, 1'b1);
                    if (ok) begin
                        check("pulse_rs", rs, v[8]);
                        check("pulse_dados", dq, v[7:0]);
                    end
                    pulses[d]++;
                    last_dq[d] = dq;
                end
                if (!en) hi_cnt[d] = 0;
                if (done && !prev_done[d]) init_cyc[d] = cyc - rel_cyc[d];
                if (vld && rdy) push_byte(d, irs, idat);
                prev_en[d]   = en;
                prev_done[d] = done;
            end
        end
    end

    task automatic wait_ready(input int d, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (rdy_of(d)) begin ok = 1'b1; break; end
        end
        check("ready_wait", ok, 1'b1);
    endtask

    // One handshake; optionally keeps In_Valid high (with other data) for 'hold' cycles afterwards.
    task automatic send(input int d, input logic rs, input logic [7:0] data, input int hold,
                        input int exp_low);
        int   lat, low;
        logic seen, ok;
        @(posedge clk); #1;
        drive(d, 1'b1, rs, data);
        wait_ready(d, ok);
        if (ok) begin
            check("idle_estado", (d == 0) ? est8 : est4, 3'd2);
            check("init_done_at_idle", (d == 0) ? done8 : done4, 1'b1);
            @(posedge clk); #1;
            if (hold == 0) drive(d, 1'b0, rs, data);
            else drive(d, 1'b1, rs, 8'h77);
            lat = 0; low = 0; seen = 1'b0; ok = 1'b0;
            for (int n = 1; n <= 5000; n++) begin
                @(negedge clk);
                if (!seen && en_of(d)) begin seen = 1'b1; lat = n; end
                if (rdy_of(d)) begin ok = 1'b1; break; end
                low++;
                if (n == hold) drive(d, 1'b0, rs, data);
            end
            check("enable_latency", lat, 2);
            check("ready_low_cycles", low, exp_low);
            check("back_to_idle", ok, 1'b1);
        end
        drive(d, 1'b0, rs, data);
    endtask

    initial begin
        logic found, ok;
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst8_estado", est8, 3'd0);   check("rst4_estado", est4, 3'd0);
        check("rst8_enable", en8, 1'b0);    check("rst4_enable", en4, 1'b0);
        check("rst8_rs", rs8, 1'b0);        check("rst8_dados", dq8, 8'h00);
        check("rst4_dados", dq4, 8'h00);    check("rst8_ready", if8.In_Ready, 1'b0);
        check("rst8_done", done8, 1'b0);    check("rst4_done", done4, 1'b0);
        @(posedge clk); #1;
        rst8 = 1'b0; rst4 = 1'b0;

        // 8-bit: In_Valid held high through the whole init, one transfer of 'A'.
        send(0, 1'b1, 8'h41, 0, 43);
        check("pulses8_after_A", pulses[0], 9);
        check("last8_dados", last_dq[0], 8'h41);
        check("init8_min", init_cyc[0] >= 6100, 1'b1);
        check("init8_max", init_cyc[0] <= 6300, 1'b1);

        // 4-bit: 0xA5 as nibbles, In_Valid kept high during EXEC must not start another byte.
        send(1, 1'b1, 8'hA5, 30, 46);
        check("pulses4_after_A5", pulses[1], 16);
        check("last4_dados", last_dq[1], 8'h50);
        check("init4_min", init_cyc[1] >= 6100, 1'b1);
        check("init4_max", init_cyc[1] <= 6300, 1'b1);
        send(1, 1'b0, 8'h3C, 0, 46);

        // Clear command on the 8-bit instance.
        send(0, 1'b0, 8'h01, 0, CLEAR_LOW);
        send(0, 1'b0, 8'h80, 0, 43);

        // Reset in the middle of an Enable pulse.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 8'h42);
        wait_ready(0, ok);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 8'h42);
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (en8) begin found = 1'b1; break; end
        end
        check("pulse_reached", found, 1'b1);
        rst8 = 1'b1;
        @(negedge clk);
        check("prst_enable", en8, 1'b0);
        check("prst_estado", est8, 3'd0);
        check("prst_done", done8, 1'b0);
        check("prst_dados", dq8, 8'h00);
        @(posedge clk); #1;
        rst8 = 1'b0;
        send(0, 1'b1, 8'h43, 0, 43);
        check("pulses8_restart", pulses[0], 9);

        repeat (5) @(negedge clk);
        check("queue8_drained", exp0.size(), 0);
        check("queue4_drained", exp1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
